// File: rtl/quire_share_sched.sv
// Round-robin scheduler that time-shares one combinational quire adder among
// NUM_REQ dot-product streams. It keeps one quire context per requester and a single-entry result buffer.
module quire_share_sched #(
   parameter int NUM_REQ    = 4,
   parameter int EXP_BITS   = 8,
   parameter int VAL_BITS   = 18,
   parameter int QUIRE_BITS = 64,
   parameter int ID_BITS    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [NUM_REQ-1:0]           reqValid,
   output logic [NUM_REQ-1:0]           reqReady,
   input  logic [NUM_REQ-1:0]           reqLast,
   input  logic [NUM_REQ-1:0]           reqClear,
   input  logic [NUM_REQ*EXP_BITS-1:0]  reqExp,
   input  logic [NUM_REQ*VAL_BITS-1:0]  reqVal,
   input  logic [NUM_REQ-1:0]           reqSign,
   input  logic [NUM_REQ-1:0]           reqInf,
   output logic [EXP_BITS-1:0]          addExp,
   output logic [VAL_BITS-1:0]          addVal,
   output logic                         addSign,
   output logic                         addInf,
   output logic [QUIRE_BITS-1:0]        addQuireIn,
   input  logic [QUIRE_BITS-1:0]        addQuireOut,
   output logic                         resValid,
   input  logic                         resReady,
   output logic [ID_BITS-1:0]           resId,
   output logic [QUIRE_BITS-1:0]        resQuire
);

   logic [QUIRE_BITS-1:0] ctx [NUM_REQ];
   logic [ID_BITS-1:0]    ptr;

   logic                  slot_free;
   logic [NUM_REQ-1:0]    elig;
   logic                  vld_p0;
   logic [ID_BITS-1:0]    gnt_id_p0;
   logic [ID_BITS-1:0]    src_id_p0;
   logic                  gnt_last_p0;
   logic                  pop;

   // Successor of a requester index with wrap, valid for any NUM_REQ.
   function automatic logic [ID_BITS-1:0] rr_next(input logic [ID_BITS-1:0] id);
      if (int'(id) >= NUM_REQ - 1)
         rr_next = '0;
      else
         rr_next = id + ID_BITS'(1);
   endfunction

   // Stage 0: eligibility, round-robin grant and adder operand mux
   always_comb begin
      slot_free = !resValid || resReady;
      elig      = reqValid & ~reqClear & (~reqLast | {NUM_REQ{slot_free}});
   end

   always_comb begin
      int idx;
      idx       = 0;
      vld_p0    = 1'b0;
      gnt_id_p0 = ptr;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ)
            idx = idx - NUM_REQ;
         if (!vld_p0 && elig[ID_BITS'(idx)]) begin
            vld_p0    = 1'b1;
            gnt_id_p0 = ID_BITS'(idx);
         end
      end
      // Nothing is accepted while reset is being applied.
      if (reset)
         vld_p0 = 1'b0;
   end

   always_comb begin
      reqReady = '0;
      if (vld_p0)
         reqReady[gnt_id_p0] = 1'b1;
   end

   // Without a grant the adder still sees a well-defined operand set (slot ptr);
   // its sum is simply not written anywhere.
   assign src_id_p0   = vld_p0 ? gnt_id_p0 : ptr;
   assign gnt_last_p0 = vld_p0 && reqLast[gnt_id_p0];
   assign pop         = resValid && resReady;

   assign addExp     = reqExp[int'(src_id_p0)*EXP_BITS +: EXP_BITS];
   assign addVal     = reqVal[int'(src_id_p0)*VAL_BITS +: VAL_BITS];
   assign addSign    = reqSign[src_id_p0];
   assign addInf     = reqInf[src_id_p0];
   assign addQuireIn = ctx[src_id_p0];

   // Stage 1: context write-back, pointer advance and result buffer
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NUM_REQ; i++)
            ctx[i] <= '0;
         ptr      <= '0;
         resValid <= 1'b0;
         resId    <= '0;
         resQuire <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++)
            if (reqClear[i])
               ctx[i] <= '0;
         if (vld_p0) begin
            ptr <= rr_next(gnt_id_p0);
            if (gnt_last_p0) begin
               ctx[gnt_id_p0] <= '0;
               resQuire       <= addQuireOut;
               resId          <= gnt_id_p0;
            end else begin
               ctx[gnt_id_p0] <= addQuireOut;
            end
         end
         // A last term granted in the pop cycle refills the buffer directly.
         if (gnt_last_p0)
            resValid <= 1'b1;
         else if (pop)
            resValid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_quire_share_sched.sv
// Bench for quire_share_sched: a Kulisch adder model closes the loop, a
// cycle-level reference model checks every output, and directed cases pin literal results.
module tb_quire_share_sched;

   localparam int N  = 4;
   localparam int EB = 8;
   localparam int VB = 18;
   localparam int QB = 64;
   localparam int IB = 2;

   localparam logic [VB-1:0] ONE = 18'h10000;

   logic             clock = 1'b0;
   logic             reset;
   logic [N-1:0]     reqValid, reqReady, reqLast, reqClear, reqSign, reqInf;
   logic [N*EB-1:0]  reqExp;
   logic [N*VB-1:0]  reqVal;
   logic [EB-1:0]    addExp;
   logic [VB-1:0]    addVal;
   logic             addSign, addInf;
   logic [QB-1:0]    addQuireIn, addQuireOut;
   logic             resValid, resReady;
   logic [IB-1:0]    resId;
   logic [QB-1:0]    resQuire;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clock = ~clock;

   quire_share_sched #(.NUM_REQ(N), .EXP_BITS(EB), .VAL_BITS(VB), .QUIRE_BITS(QB)) dut (
      .clock(clock), .reset(reset),
      .reqValid(reqValid), .reqReady(reqReady), .reqLast(reqLast), .reqClear(reqClear),
      .reqExp(reqExp), .reqVal(reqVal), .reqSign(reqSign), .reqInf(reqInf),
      .addExp(addExp), .addVal(addVal), .addSign(addSign), .addInf(addInf),
      .addQuireIn(addQuireIn), .addQuireOut(addQuireOut),
      .resValid(resValid), .resReady(resReady), .resId(resId), .resQuire(resQuire)
   );

   // Quire format used by this bench: bit 63 = sticky inf, bits 62:0 = two's complement fixed point with 32 fraction bits.
   // Products are mm.ffff * 2^(exp-127).
   function automatic logic [QB-1:0] kadd(input logic [QB-1:0] q, input logic [EB-1:0] e,
                                          input logic [VB-1:0] v, input logic s, input logic inf);
      logic [62:0] t;
      int          sh;
      t  = 63'(v) << 16;
      sh = int'(e) - 127;
      if (sh >= 0) t = t << sh;
      else         t = t >> (-sh);
      if (s) t = -t;
      kadd[63]   = q[63] | inf;
      kadd[62:0] = inf ? q[62:0] : q[62:0] + t;
   endfunction

   assign addQuireOut = kadd(addQuireIn, addExp, addVal, addSign, addInf);

   task automatic chk(input string nm, input logic [QB-1:0] got, input logic [QB-1:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s got=%h want=%h at %0t", nm, got, want, $time);
   endtask

   // Reference model: per-requester contexts, pointer, and result buffer.
   logic [QB-1:0] m_ctx [N];
   int            m_ptr;
   logic          m_rv;
   int            m_rid;
   logic [QB-1:0] m_rq;

   always @(negedge clock) begin
      int            g, src, ii;
      logic          free, pop, lastg;
      logic [N-1:0]  want_rdy;
      logic [QB-1:0] sum;
      if (reset) begin
         chk("rdy_in_reset", QB'(reqReady), '0);
         for (int i = 0; i < N; i++) m_ctx[i] = '0;
         m_ptr = 0; m_rv = 1'b0; m_rid = 0; m_rq = '0;
      end else begin
         free = !m_rv || resReady;
         g = -1;
         for (int k = 0; k < N; k++) begin
            ii = (m_ptr + k) % N;
            if (g < 0 && reqValid[ii] && !reqClear[ii] && (!reqLast[ii] || free))
               g = ii;
         end
         want_rdy = (g >= 0) ? N'(1) << g : '0;
         src = (g >= 0) ? g : m_ptr;
         chk("reqReady", QB'(reqReady), QB'(want_rdy));
         chk("addQuireIn", addQuireIn, m_ctx[src]);
         chk("addExp", QB'(addExp), QB'(reqExp[src*EB +: EB]));
         chk("addVal", QB'(addVal), QB'(reqVal[src*VB +: VB]));
         chk("addSignInf", QB'({addSign, addInf}), QB'({reqSign[src], reqInf[src]}));
         chk("resValid", QB'(resValid), QB'(m_rv));
         chk("resId", QB'(resId), QB'(m_rid));
         chk("resQuire", resQuire, m_rq);
         sum   = kadd(m_ctx[src], reqExp[src*EB +: EB], reqVal[src*VB +: VB], reqSign[src], reqInf[src]);
         pop   = m_rv && resReady;
         lastg = (g >= 0) && reqLast[g];
         for (int i = 0; i < N; i++) if (reqClear[i]) m_ctx[i] = '0;
         if (g >= 0) begin
            if (lastg) begin
               m_rq = sum; m_rid = g; m_ctx[g] = '0;
            end else begin
               m_ctx[g] = sum;
            end
            m_ptr = (g + 1) % N;
         end
         if (lastg)    m_rv = 1'b1;
         else if (pop) m_rv = 1'b0;
      end
   end

   task automatic step();
      @(posedge clock); #1;
   endtask

   task automatic clr_in();
      reqValid = '0; reqLast = '0; reqClear = '0; reqSign = '0; reqInf = '0;
      reqExp = '0; reqVal = '0;
   endtask

   task automatic term(input int i, input logic last, input logic [EB-1:0] e,
                       input logic [VB-1:0] v, input logic s, input logic inf);
      reqValid[i] = 1'b1; reqLast[i] = last; reqSign[i] = s; reqInf[i] = inf;
      reqExp[i*EB +: EB] = e; reqVal[i*VB +: VB] = v;
   endtask

   task automatic do_reset();
      reset = 1'b1; clr_in(); step(); reset = 1'b0;
   endtask

   logic [N-1:0] rot_exp [6];
   logic [N-1:0] inf_exp [5];

   initial begin
      rot_exp = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd1, 4'd2};
      inf_exp = '{4'd1, 4'd2, 4'd1, 4'd2, 4'd1};
      reset = 1'b1; resReady = 1'b1; clr_in();
      step(); step(); reset = 1'b0;

      // Three terms on requester 0: 1.0 + 2.0 - 0.5
      term(0, 0, 8'd127, ONE, 0, 0); @(negedge clock); chk("t1_g1", QB'(reqReady), 64'd1); step();
      clr_in(); term(0, 0, 8'd128, ONE, 0, 0); @(negedge clock); chk("t1_g2", QB'(reqReady), 64'd1); step();
      clr_in(); term(0, 1, 8'd126, ONE, 1, 0); @(negedge clock); chk("t1_g3", QB'(reqReady), 64'd1); step();
      clr_in(); @(negedge clock);
      chk("t1_vld", QB'(resValid), 64'd1);
      chk("t1_q", resQuire, 64'h0000_0002_8000_0000);
      chk("t1_id", QB'(resId), 64'd0);
      step();
      term(0, 1, 8'd127, ONE, 0, 0); @(negedge clock); chk("t1_g4", QB'(reqReady), 64'd1); step();
      clr_in(); @(negedge clock); chk("t1_ctx0_zero", resQuire, 64'h0000_0001_0000_0000); step();

      // Rotation with all requesters busy on non-last terms
      do_reset();
      for (int i = 0; i < N; i++) term(i, 0, 8'd127, ONE, 0, 0);
      for (int k = 0; k < 6; k++) begin
         @(negedge clock); chk("rot", QB'(reqReady), QB'(rot_exp[k])); step();
      end

      // Backpressure: full buffer blocks only requester 1's last term
      do_reset(); resReady = 1'b0;
      term(0, 1, 8'd127, ONE, 0, 0); @(negedge clock); chk("bp_fill", QB'(reqReady), 64'd1); step();
      clr_in(); term(1, 1, 8'd128, ONE, 0, 0); term(2, 0, 8'd127, ONE, 0, 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         chk("bp_only2", QB'(reqReady), 64'd4);
         chk("bp_vld", QB'(resValid), 64'd1);
         chk("bp_id0", QB'(resId), 64'd0);
         step();
      end
      resReady = 1'b1; @(negedge clock); chk("bp_pop_g1", QB'(reqReady), 64'd2); step();
      clr_in(); resReady = 1'b0; @(negedge clock);
      chk("bp_refill_vld", QB'(resValid), 64'd1);
      chk("bp_refill_id", QB'(resId), 64'd1);
      chk("bp_refill_q", resQuire, 64'h0000_0002_0000_0000);
      step(); resReady = 1'b1; step();

      // Clear collides with a valid term on requester 3
      do_reset();
      term(3, 0, 8'd129, 18'h1C000, 0, 0); @(negedge clock); chk("clr_acc", QB'(reqReady), 64'd8); step();
      reqClear[3] = 1'b1; term(3, 1, 8'd127, ONE, 0, 0);
      @(negedge clock); chk("clr_nogrant", QB'(reqReady), 64'd0); step();
      reqClear[3] = 1'b0; @(negedge clock); chk("clr_grant", QB'(reqReady), 64'd8); step();
      clr_in(); @(negedge clock);
      chk("clr_q", resQuire, 64'h0000_0001_0000_0000);
      chk("clr_id", QB'(resId), 64'd3);
      step();

      // Reset in the middle of a dot product on requester 2
      do_reset();
      term(2, 0, 8'd129, 18'h14000, 0, 0); @(negedge clock); chk("rst_acc", QB'(reqReady), 64'd4); step();
      reset = 1'b1; @(negedge clock); chk("rst_rdy0", QB'(reqReady), 64'd0); step();
      reset = 1'b0; clr_in(); term(0, 0, 8'd127, ONE, 0, 0); term(3, 0, 8'd127, ONE, 0, 0);
      @(negedge clock);
      chk("rst_ptr0", QB'(reqReady), 64'd1);
      chk("rst_vld0", QB'(resValid), 64'd0);
      step();
      clr_in(); term(2, 1, 8'd127, ONE, 0, 0); @(negedge clock); chk("rst_g2", QB'(reqReady), 64'd4); step();
      clr_in(); @(negedge clock);
      chk("rst_q", resQuire, 64'h0000_0001_0000_0000);
      chk("rst_id", QB'(resId), 64'd2);
      step();

      // Inf term mid-sequence on requester 0, requester 1 busy alongside
      do_reset();
      term(1, 0, 8'd127, ONE, 0, 0);
      for (int k = 0; k < 5; k++) begin
         case (k)
            0:       term(0, 0, 8'd127, ONE, 0, 0);
            1, 2:    term(0, 0, 8'd127, ONE, 0, 1);
            default: term(0, 1, 8'd127, ONE, 0, 0);
         endcase
         @(negedge clock); chk("inf_order", QB'(reqReady), QB'(inf_exp[k])); step();
      end
      clr_in(); @(negedge clock);
      chk("inf_q", resQuire, 64'h8000_0002_0000_0000);
      chk("inf_id", QB'(resId), 64'd0);
      step();

      // Randomized traffic, checked by the reference model every cycle
      for (int c = 0; c < 3000; c++) begin
         reset    = ($urandom_range(0, 199) == 0);
         resReady = ($urandom_range(0, 2) != 0);
         reqValid = N'($urandom);
         for (int i = 0; i < N; i++) begin
            reqLast[i]  = ($urandom_range(0, 5) == 0);
            reqClear[i] = ($urandom_range(0, 15) == 0);
            reqInf[i]   = ($urandom_range(0, 31) == 0);
            reqSign[i]  = 1'($urandom);
            reqExp[i*EB +: EB] = EB'($urandom_range(120, 134));
            reqVal[i*VB +: VB] = VB'($urandom);
         end
         step();
      end
      reset = 1'b0; clr_in();
      step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
